adc_sample_collector: RTL and testbench

Downstream consumer of the readout controller's four one-cycle start_adc strobes. Runs four independent AD7673 conversion/serial-read engines, one per ADC. Tags each result with its pixel index within the line and funnels all results through one FIFO to the host-transfer stage over a valid/ready stream.

---
 rtl/adc_sample_collector.sv | 233 +++++++++++++++++++++++
 tb/tb_adc_sample_collector.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_collector.sv
// Four independent AD7673 convert/serial-read engines feeding one FWFT output FIFO.
// Optional build macro ADC_TEST_PATTERN_EN adds test_mode, which bypasses the ADC pins with a tagged pattern.
module adc_sample_collector #(
    parameter int unsigned DATA_BITS      = 18,
    parameter int unsigned CNV_LOW_CYCLES = 4,
    parameter int unsigned SCLK_HALF      = 1,
    parameter int unsigned BUSY_TIMEOUT   = 200,
    parameter int unsigned INDEX_BITS     = 7,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            start_adc,
    input  logic                  frame_sync,
    output logic [3:0]            adc_cnvst_n,
    input  logic [3:0]            adc_busy,
    output logic [3:0]            adc_sclk,
    input  logic [3:0]            adc_sdout,
`ifdef ADC_TEST_PATTERN_EN
    input  logic                  test_mode,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_BITS-1:0]  out_data,
    output logic [INDEX_BITS-1:0] out_index,
    output logic [1:0]            out_channel,
    output logic                  out_err,
    output logic [3:0]            overrun,
    output logic                  fifo_overflow,
    input  logic                  clear_flags
);

    localparam int unsigned NCH  = 4;
    localparam int unsigned PW   = DATA_BITS + INDEX_BITS + 3;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = $clog2(BUSY_TIMEOUT + CNV_LOW_CYCLES + SCLK_HALF + 4);
    localparam int unsigned BW   = $clog2(DATA_BITS + 1);
`ifdef ADC_TEST_PATTERN_EN
    localparam int unsigned PADW = DATA_BITS - INDEX_BITS - 2;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_CONVERT, S_WAIT, S_SHIFT, S_DONE
    } eng_state_t;

    logic [INDEX_BITS-1:0]          idx_cnt;
    logic [INDEX_BITS-1:0]          idx_acc;
    logic [NCH-1:0][INDEX_BITS-1:0] start_idx;
    logic [NCH-1:0]                 hold_full;
    logic [NCH-1:0]                 grant;
    logic [NCH-1:0]                 overrun_evt;
    logic [NCH-1:0]                 ovf_evt;
    logic [PW-1:0]                  hold_payload [NCH];

    logic [PW-1:0]                  mem [FIFO_DEPTH];
    logic [AW-1:0]                  wr_ptr, rd_ptr, rd_ptr_next;
    logic [AW:0]                    count, count_next;
    logic                           push, pop;
    logic [1:0]                     sel;
    logic [PW-1:0]                  push_payload, head_next;

    // Indices for simultaneous starts are handed out in ascending bit order.
    always_comb begin
        idx_acc   = frame_sync ? '0 : idx_cnt;
        start_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            start_idx[i] = idx_acc;
            idx_acc      = idx_acc + INDEX_BITS'(start_adc[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_cnt       <= '0;
            overrun       <= '0;
            fifo_overflow <= 1'b0;
        end else begin
            idx_cnt       <= idx_acc;
            overrun       <= (clear_flags ? 4'b0000 : overrun) | overrun_evt;
            fifo_overflow <= (fifo_overflow & ~clear_flags) | (|ovf_evt);
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_eng
        eng_state_t            state;
        logic [CW-1:0]         cnt;
        logic [BW-1:0]         bit_cnt;
        logic [DATA_BITS-1:0]  shreg;
        logic [INDEX_BITS-1:0] idx_q;
        logic                  err_q;
        logic                  cnvst_q;
        logic                  sclk_q;
        logic                  full_q;
        logic [PW-1:0]         payload_q;

        assign adc_cnvst_n[g]  = cnvst_q;
        assign adc_sclk[g]     = sclk_q;
        assign hold_full[g]    = full_q;
        assign hold_payload[g] = payload_q;
        assign overrun_evt[g]  = start_adc[g] && (state != S_IDLE);
        assign ovf_evt[g]      = (state == S_DONE) && full_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state     <= S_IDLE;
                cnt       <= '0;
                bit_cnt   <= '0;
                shreg     <= '0;
                idx_q     <= '0;
                err_q     <= 1'b0;
                cnvst_q   <= 1'b1;
                sclk_q    <= 1'b0;
                full_q    <= 1'b0;
                payload_q <= '0;
            end else begin
                if (grant[g]) full_q <= 1'b0;
                case (state)
                    S_IDLE: begin
                        if (start_adc[g]) begin
                            idx_q <= start_idx[g];
                            err_q <= 1'b0;
                            cnt   <= '0;
`ifdef ADC_TEST_PATTERN_EN
                            if (test_mode) begin
                                shreg <= {2'(g), {PADW{1'b0}}, start_idx[g]};
                                state <= S_DONE;
                            end else begin
                                cnvst_q <= 1'b0;
                                state   <= S_CONVERT;
                            end
`else
                            cnvst_q <= 1'b0;
                            state   <= S_CONVERT;
`endif
                        end
                    end
                    S_CONVERT: begin
                        if (cnt == CW'(CNV_LOW_CYCLES - 1)) begin
                            cnvst_q <= 1'b1;
                            cnt     <= '0;
                            state   <= S_WAIT;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    // BUSY is not yet valid for the first two cycles after cnvst_n rises.
                    S_WAIT: begin
                        if (cnt >= CW'(2) && !adc_busy[g]) begin
                            sclk_q  <= 1'b1;
                            shreg   <= {shreg[DATA_BITS-2:0], adc_sdout[g]};
                            bit_cnt <= '0;
                            cnt     <= '0;
                            state   <= S_SHIFT;
                        end else if (cnt == CW'(BUSY_TIMEOUT + 1)) begin
                            err_q <= 1'b1;
                            shreg <= '0;
                            state <= S_DONE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    // Each sclk rise captures one bit; the sample ends after the last low half.
                    S_SHIFT: begin
                        if (cnt == CW'(SCLK_HALF - 1)) begin
                            cnt <= '0;
                            if (sclk_q) begin
                                sclk_q <= 1'b0;
                            end else if (bit_cnt == BW'(DATA_BITS - 1)) begin
                                state <= S_DONE;
                            end else begin
                                sclk_q  <= 1'b1;
                                shreg   <= {shreg[DATA_BITS-2:0], adc_sdout[g]};
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_DONE: begin
                        if (!full_q) begin
                            full_q    <= 1'b1;
                            payload_q <= {shreg, idx_q, 2'(g), err_q};
                            state     <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Lowest-numbered full holding register wins; a full FIFO still accepts when popping.
    always_comb begin
        sel = '0;
        for (int i = NCH; i > 0; i--) begin
            if (hold_full[i-1]) sel = 2'(i - 1);
        end
        push  = (|hold_full) && ((count != (AW+1)'(FIFO_DEPTH)) || pop);
        grant = '0;
        if (push) grant[sel] = 1'b1;
        push_payload = hold_payload[sel];
    end

    assign pop         = out_valid && out_ready;
    assign rd_ptr_next = rd_ptr + AW'(pop);
    assign count_next  = count + (AW+1)'(push) - (AW+1)'(pop);
    assign head_next   = (push && (wr_ptr == rd_ptr_next)) ? push_payload : mem[rd_ptr_next];

    // Registered first-word-fall-through head; bypasses a push that lands on the new head slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_index   <= '0;
            out_channel <= '0;
            out_err     <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_payload;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            rd_ptr    <= rd_ptr_next;
            count     <= count_next;
            out_valid <= (count_next != '0);
            {out_data, out_index, out_channel, out_err} <= head_next;
        end
    end

endmodule

// File: tb/tb_adc_sample_collector.sv
// Scoreboard bench for adc_sample_collector with a behavioural AD7673 model per channel.
`timescale 1ns/1ps
module tb_adc_sample_collector;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  start_adc;
    logic        frame_sync;
    logic [3:0]  adc_cnvst_n;
    logic [3:0]  adc_busy;
    logic [3:0]  adc_sclk;
    logic [3:0]  adc_sdout;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_data;
    logic [6:0]  out_index;
    logic [1:0]  out_channel;
    logic        out_err;
    logic [3:0]  overrun;
    logic        fifo_overflow;
    logic        clear_flags;
`ifdef ADC_TEST_PATTERN_EN
    logic        test_mode = 1'b0;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [27:0] exp_q[$];
    logic [17:0] adc_val [4];
    int          busy_len [4];

    always #4 clk = ~clk;

    adc_sample_collector dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start_adc     (start_adc),
        .frame_sync    (frame_sync),
        .adc_cnvst_n   (adc_cnvst_n),
        .adc_busy      (adc_busy),
        .adc_sclk      (adc_sclk),
        .adc_sdout     (adc_sdout),
`ifdef ADC_TEST_PATTERN_EN
        .test_mode     (test_mode),
`endif
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_index     (out_index),
        .out_channel   (out_channel),
        .out_err       (out_err),
        .overrun       (overrun),
        .fifo_overflow (fifo_overflow),
        .clear_flags   (clear_flags)
    );

    // ADC model: BUSY follows cnvst_n falling; MSB first, next bit after each sclk fall.
    for (genvar c = 0; c < 4; c++) begin : g_adc
        logic        busy_r;
        logic [17:0] sr;
        assign adc_busy[c]  = busy_r;
        assign adc_sdout[c] = sr[17];
        initial begin
            busy_r = 1'b0;
            forever begin
                @(negedge adc_cnvst_n[c]);
                @(negedge clk);
                busy_r = 1'b1;
                repeat (busy_len[c]) @(negedge clk);
                busy_r = 1'b0;
            end
        end
        initial begin
            sr = '0;
            forever begin
                @(negedge adc_cnvst_n[c] or negedge adc_sclk[c]);
                if (!adc_cnvst_n[c]) sr = adc_val[c];
                else                 sr = sr << 1;
            end
        end
    end

    // Monitor: every accepted head is compared against the oldest expectation.
    initial begin
        logic [27:0] e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got data=%h idx=%0d ch=%0d err=%0b",
                             out_data, out_index, out_channel, out_err);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_data, out_index, out_channel, out_err} !== e) begin
                        errors++;
                        $display("FAIL sample got data=%h idx=%0d ch=%0d err=%0b exp data=%h idx=%0d ch=%0d err=%0b",
                                 out_data, out_index, out_channel, out_err,
                                 e[27:10], e[9:3], e[2:1], e[0]);
                    end
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] mask, input logic fs);
        @(posedge clk); #1;
        start_adc  = mask;
        frame_sync = fs;
        @(posedge clk); #1;
        start_adc  = '0;
        frame_sync = 1'b0;
    endtask

    task automatic expect_sample(input logic [17:0] d, input int idx, input int ch, input logic err);
        exp_q.push_back({d, 7'(idx), 2'(ch), err});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_sclk(input int ch);
        int n = 0;
        while (!adc_sclk[ch] && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("sclk_seen", 32'(adc_sclk[ch]), 32'd1);
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1; clear_flags = 1'b1;
        @(posedge clk); #1; clear_flags = 1'b0;
    endtask

    function automatic logic [17:0] pat(input int k);
        return 18'(k * 2731) ^ 18'h2D2D5;
    endfunction

    initial begin
        int n, rises;
        logic prev;
        int order_line [4] = '{1, 3, 0, 2};
        int order_ovf [13] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 3};

        reset_n = 1'b0; start_adc = '0; frame_sync = 1'b0;
        out_ready = 1'b1; clear_flags = 1'b0;
        for (int i = 0; i < 4; i++) begin adc_val[i] = '0; busy_len[i] = 20; end

        #20;
        check("rst_cnvst", 32'(adc_cnvst_n), 32'hF);
        check("rst_sclk", 32'(adc_sclk), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_index", 32'(out_index), 32'h0);
        check("rst_channel", 32'(out_channel), 32'h0);
        check("rst_err", 32'(out_err), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_fifo_ovf", 32'(fifo_overflow), 32'h0);
        @(negedge clk); reset_n = 1'b1;

        // Single conversion on adc2
        adc_val[1] = 18'h2A5C3; busy_len[1] = 80;
        issue(4'b0000, 1'b1);
        expect_sample(18'h2A5C3, 0, 1, 1'b0);
        issue(4'b0010, 1'b0);
        n = 0;
        while (!adc_cnvst_n[1] && n < 20) begin n++; @(posedge clk); #1; end
        check("cnvst_low_cycles", 32'(n), 32'd4);
        rises = 0; prev = adc_sclk[1]; n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            if (adc_sclk[1] && !prev) rises++;
            prev = adc_sclk[1];
            n++;
        end
        check("sclk_pulses", 32'(rises), 32'd18);
        check("single_drain", 32'(exp_q.size()), 32'd0);
        busy_len[1] = 20;

        // Controller-order line, 128 starts 32 cycles apart
        issue(4'b0000, 1'b1);
        for (int k = 0; k < 128; k++) begin
            int ch;
            ch = order_line[k % 4];
            adc_val[ch] = pat(k);
            expect_sample(pat(k), k, ch, 1'b0);
            issue(4'(1 << ch), 1'b0);
            repeat (30) @(posedge clk);
            #1;
        end
        wait_drain("line", 300);
        check("line_overrun", 32'(overrun), 32'h0);
        check("line_fifo_ovf", 32'(fifo_overflow), 32'h0);

        // BUSY stuck high: DONE at start+4+2+200, one cycle to hold, one to FIFO head
        busy_len[2] = 300;
        issue(4'b0000, 1'b1);
        expect_sample(18'h0, 0, 2, 1'b1);
        issue(4'b0100, 1'b0);
        n = 0;
        while (!out_valid && n < 400) begin @(posedge clk); #1; n++; end
        check("timeout_latency", 32'(n), 32'd208);
        wait_drain("timeout", 20);
        repeat (120) @(posedge clk);
        #1;
        busy_len[2] = 20;

        // Overrun: second start on adc1 while it shifts
        issue(4'b0000, 1'b1);
        adc_val[0] = 18'h30F0F;
        expect_sample(18'h30F0F, 0, 0, 1'b0);
        issue(4'b0001, 1'b0);
        wait_sclk(0);
        issue(4'b0001, 1'b0);
        wait_drain("overrun1", 200);
        check("overrun_set", 32'(overrun), 32'h1);
        adc_val[0] = 18'h0ABCD;
        expect_sample(18'h0ABCD, 2, 0, 1'b0);
        issue(4'b0001, 1'b0);
        wait_drain("overrun2", 200);
        check("overrun_sticky", 32'(overrun), 32'h1);
        pulse_clear();
        check("overrun_cleared", 32'(overrun), 32'h0);
        adc_val[0] = 18'h12345;
        expect_sample(18'h12345, 3, 0, 1'b0);
        issue(4'b0001, 1'b0);
        repeat (10) @(posedge clk);
        #1; start_adc = 4'b0001; clear_flags = 1'b1;
        @(posedge clk); #1; start_adc = 4'b0000; clear_flags = 1'b0;
        check("overrun_set_wins", 32'(overrun), 32'h1);
        wait_drain("overrun3", 200);
        adc_val[0] = 18'h00777;
        expect_sample(18'h00777, 5, 0, 1'b0);
        issue(4'b0001, 1'b0);
        wait_drain("overrun4", 200);
        pulse_clear();
        check("overrun_cleared2", 32'(overrun), 32'h0);

        // Back-pressure: 13 samples, 8 in FIFO, 4 in holding registers, adc4 stalls in DONE
        out_ready = 1'b0;
        issue(4'b0000, 1'b1);
        for (int k = 0; k < 13; k++) begin
            int ch;
            ch = order_ovf[k];
            if (k == 12) begin
                repeat (100) @(posedge clk);
                #1;
            end
            adc_val[ch] = pat(k + 200);
            expect_sample(pat(k + 200), k, ch, 1'b0);
            issue(4'(1 << ch), 1'b0);
            repeat (30) @(posedge clk);
            #1;
        end
        repeat (100) @(posedge clk);
        #1;
        check("bp_fifo_ovf", 32'(fifo_overflow), 32'h1);
        check("bp_valid", 32'(out_valid), 32'h1);
        check("bp_head_index", 32'(out_index), 32'd0);
        check("bp_head_data", 32'(out_data), 32'(pat(200)));
        check("bp_overrun", 32'(overrun), 32'h0);
        out_ready = 1'b1;
        wait_drain("bp", 100);
        pulse_clear();
        check("fifo_ovf_cleared", 32'(fifo_overflow), 32'h0);

        // Reset while adc3 shifts and a sample from adc2 waits in the FIFO
        out_ready = 1'b0;
        busy_len[1] = 5; busy_len[2] = 60;
        adc_val[1] = 18'h1FFFF; adc_val[2] = 18'h2AAAA;
        issue(4'b0000, 1'b1);
        issue(4'b0110, 1'b0);
        wait_sclk(2);
        check("pre_rst_valid", 32'(out_valid), 32'h1);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_cnvst", 32'(adc_cnvst_n), 32'hF);
        check("mid_rst_sclk", 32'(adc_sclk), 32'h0);
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_data", 32'(out_data), 32'h0);
        check("mid_rst_channel", 32'(out_channel), 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (150) @(posedge clk);
        #1;
        check("post_rst_valid", 32'(out_valid), 32'h0);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
